// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice: widths, state encoding,
// round-key type, the forward S-box and the round-constant lookup.
package aes_pkg;

    localparam int KEY_W          = 128;
    localparam int NUM_ROUNDS_MAX = 10;

    typedef logic [127:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } keyexp_state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte substitution through the forward S-box.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constant for rounds 1..10; anything else yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_key_expander_keygenerate.sv
// One round of the AES-128 key expansion: derives round key `rnd` from the
// previous round key. Purely combinational.
module keygenerate
    import aes_pkg::*;
(
    input  round_key_t  prev_key,
    input  logic [3:0]  rnd,
    output round_key_t  next_key
);

    // RotWord, SubWord, then fold the round constant into the top byte.
    function automatic logic [31:0] g_func(input logic [31:0] w, input logic [3:0] r);
        logic [31:0] rot;
        rot = {w[23:0], w[31:24]};
        return {sbox(rot[31:24]) ^ rcon(r), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;

    // Each new word chains off the one before it.
    always_comb begin
        n0 = w0 ^ g_func(w3, rnd);
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
    end

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule with an indexed, registered read port.
// Optional macro AES_KEYEXP_ZEROIZE_EN adds a `zeroize` input that wipes the
// stored schedule and returns the expander to IDLE.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_W      = aes_pkg::KEY_W,
    parameter int NUM_ROUNDS = NUM_ROUNDS_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [KEY_W-1:0] load_key,
    output logic             keys_valid,
    input  logic             rd_en,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key,
    output logic             rd_vld
`ifdef AES_KEYEXP_ZEROIZE_EN
    ,
    input  logic             zeroize
`endif
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    keyexp_state_t state_q, state_d;
    round_key_t    rk [0:NUM_ROUNDS];
    logic [3:0]    cnt_q;
    logic          accept;
    logic          zero_req;
    round_key_t    gen_in, gen_out;

`ifdef AES_KEYEXP_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d    = state_q;
        load_ready = 1'b0;
        keys_valid = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) state_d = EXPAND;
            end
            EXPAND: begin
                if (cnt_q == LAST) state_d = READY;
            end
            READY: begin
                load_ready = 1'b1;
                keys_valid = 1'b1;
                if (load_valid) state_d = EXPAND;
            end
            default: state_d = IDLE;
        endcase
        accept = load_valid && load_ready && !zero_req;
        if (zero_req) state_d = IDLE;
    end

    // The single expansion round always works from the most recently written key.
    assign gen_in = rk[cnt_q - 4'd1];

    keygenerate u_keygenerate (
        .prev_key (gen_in),
        .rnd      (cnt_q),
        .next_key (gen_out)
    );

    // Round-key storage and round counter.
    always_ff @(posedge clk) begin
        if (rst || zero_req) begin
            // NOTE: the key array is deliberately reset/cleared so no key material survives rst or zeroize.
            for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            rk[0] <= load_key;
            cnt_q <= 4'd1;
        end else if (state_q == EXPAND) begin
            rk[cnt_q] <= gen_out;
            if (cnt_q != LAST) cnt_q <= cnt_q + 4'd1;
        end
    end

    // Registered read port; sees the array as it was before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (zero_req)   rd_key <= '0;
            else if (rd_en) rd_key <= (keys_valid && rd_idx <= LAST) ? rk[rd_idx] : '0;
        end
    end

endmodule
